// File: rtl/fetch_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_sequencer_if
//  Description : Instruction-memory read channel, downstream instruction
//                channel and branch-condition input of the fetch sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fetch_sequencer_if;
    // instruction-memory read channel
    logic       imem_req;
    logic [7:0] imem_addr;
    logic       imem_ack;
    logic [7:0] imem_data;
    // downstream instruction channel
    logic       instr_valid;
    logic       instr_ready;
    logic [7:0] instr_out;
    // branch condition from execute
    logic       branch_take;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_data,
        output instr_valid,
        input  instr_ready,
        output instr_out,
        input  branch_take
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_data,
        input  instr_valid,
        output instr_ready,
        input  instr_out,
        output branch_take
    );
endinterface
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_sequencer
//  Description : Fetches opcodes from instruction memory, issues non-branch
//                opcodes downstream, resolves two-byte conditional branches
//                and stops on the halt opcode.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_sequencer #(
    parameter logic [7:0] HALT_OP = 8'hFF,
    parameter logic [3:0] BR_NIB  = 4'hB
) (
    input  wire logic        clk,
    input  wire logic        reset,
    input  wire logic        start,
    fetch_sequencer_if.master bus,
    output logic [7:0]       pc,
    output logic             halted,
    output logic [1:0]       flags
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        ISSUE  = 3'd2,
        OPER   = 3'd3,
        BRANCH = 3'd4,
        HALT   = 3'd5
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [7:0] opcode;
    logic [7:0] offset;

    // 9-bit sums: bit 8 is the carry out of bit 7 that feeds the sticky flag
    logic [8:0] inc_sum;
    logic [8:0] next_sum;
    logic [8:0] tgt_sum;
    logic       backward;

    assign inc_sum  = {1'b0, pc} + 9'd1;
    assign next_sum = {1'b0, pc} + 9'd2;
    assign tgt_sum  = {1'b0, next_sum[7:0]} + {1'b0, offset};
    assign backward = (tgt_sum[7:0] < next_sum[7:0]);

    // The offered opcode is simply the latched one; it cannot move while in ISSUE
    assign bus.instr_out = opcode;
    assign halted        = (state == HALT);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and handshake outputs
    always_comb begin
        state_next      = state;
        bus.imem_req    = 1'b0;
        bus.imem_addr   = pc;
        bus.instr_valid = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = FETCH;
                end
            end
            FETCH: begin
                bus.imem_req = 1'b1;
                if (bus.imem_ack) begin
                    if (bus.imem_data == HALT_OP) begin
                        state_next = HALT;
                    end else if (bus.imem_data[7:4] == BR_NIB) begin
                        state_next = OPER;
                    end else begin
                        state_next = ISSUE;
                    end
                end
            end
            ISSUE: begin
                bus.instr_valid = 1'b1;
                if (bus.instr_ready) begin
                    state_next = FETCH;
                end
            end
            OPER: begin
                bus.imem_req  = 1'b1;
                bus.imem_addr = inc_sum[7:0];
                if (bus.imem_ack) begin
                    state_next = BRANCH;
                end
            end
            BRANCH: begin
                state_next = FETCH;
            end
            HALT: begin
                state_next = HALT;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: opcode/offset capture, pc update and flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc     <= 8'h00;
            flags  <= 2'b00;
            opcode <= 8'h00;
            offset <= 8'h00;
        end else begin
            case (state)
                FETCH: begin
                    if (bus.imem_ack) begin
                        opcode <= bus.imem_data;
                    end
                end
                ISSUE: begin
                    if (bus.instr_ready) begin
                        pc <= inc_sum[7:0];
                        if (inc_sum[8]) begin
                            flags[1] <= 1'b1;
                        end
                    end
                end
                OPER: begin
                    if (bus.imem_ack) begin
                        offset <= bus.imem_data;
                    end
                end
                BRANCH: begin
                    if (bus.branch_take) begin
                        pc       <= tgt_sum[7:0];
                        flags[1] <= flags[1] | next_sum[8] | tgt_sum[8];
                        flags[0] <= backward;
                    end else begin
                        pc       <= next_sum[7:0];
                        flags[1] <= flags[1] | next_sum[8];
                        flags[0] <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_sequencer
//  Description : Directed self-checking bench for fetch_sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_sequencer;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] pc;
    logic       halted;
    logic [1:0] flags;

    int compared;
    int mismatched;

    fetch_sequencer_if bus ();

    fetch_sequencer #(
        .HALT_OP (8'hFF),
        .BR_NIB  (4'hB)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .bus    (bus.master),
        .pc     (pc),
        .halted (halted),
        .flags  (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // advance one clock; inputs are driven and outputs sampled 1 time unit after the edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // reset, start, then run n zero-wait non-branch instructions so pc = n in FETCH
    task automatic goto_pc(input int n);
        bus.imem_ack    = 1'b0;
        bus.instr_ready = 1'b0;
        bus.branch_take = 1'b0;
        start           = 1'b0;
        reset           = 1'b1;
        cyc();
        reset = 1'b0;
        cyc();
        start = 1'b1;
        cyc();
        start           = 1'b0;
        bus.imem_ack    = 1'b1;
        bus.imem_data   = 8'h01;
        bus.instr_ready = 1'b1;
        repeat (2 * n) cyc();
        bus.imem_ack    = 1'b0;
        bus.instr_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cyc();
        cyc();
        compared++;
        if (pc !== 8'h00 || flags !== 2'b00 || halted !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_regs: got pc=%h flags=%b halted=%b want pc=00 flags=00 halted=0", pc, flags, halted);
        end
        compared++;
        if (bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0 || bus.instr_out !== 8'h00) begin
            mismatched++;
            $display("FAIL reset_outs: got req=%b valid=%b out=%h want 0 0 00", bus.imem_req, bus.instr_valid, bus.instr_out);
        end
        reset = 1'b0;
        bus.imem_ack = 1'b1;
        bus.imem_data = 8'h12;
        repeat (3) cyc();
        bus.imem_ack = 1'b0;
        compared++;
        if (bus.imem_req !== 1'b0 || pc !== 8'h00) begin
            mismatched++;
            $display("FAIL idle_hold: got req=%b pc=%h want req=0 pc=00", bus.imem_req, pc);
        end
    endtask

    task automatic test_issue_handshake();
        start = 1'b1;
        cyc();
        start = 1'b0;
        compared++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 8'h00) begin
            mismatched++;
            $display("FAIL fetch_c1: got req=%b addr=%h want 1 00", bus.imem_req, bus.imem_addr);
        end
        cyc();
        compared++;
        if (bus.imem_req !== 1'b1) begin
            mismatched++;
            $display("FAIL fetch_c2: got req=%b want 1", bus.imem_req);
        end
        cyc();
        bus.imem_ack  = 1'b1;
        bus.imem_data = 8'h12;
        compared++;
        if (bus.imem_req !== 1'b1 || bus.instr_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL fetch_c3: got req=%b valid=%b want 1 0", bus.imem_req, bus.instr_valid);
        end
        cyc();
        bus.imem_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) bus.instr_ready = 1'b1;
            compared++;
            if (bus.instr_valid !== 1'b1 || bus.instr_out !== 8'h12 || bus.imem_req !== 1'b0) begin
                mismatched++;
                $display("FAIL issue_c%0d: got valid=%b out=%h req=%b want 1 12 0", i, bus.instr_valid, bus.instr_out, bus.imem_req);
            end
            cyc();
        end
        bus.instr_ready = 1'b0;
        compared++;
        if (bus.instr_valid !== 1'b0 || pc !== 8'h01 || bus.imem_req !== 1'b1 || bus.imem_addr !== 8'h01) begin
            mismatched++;
            $display("FAIL issue_done: got valid=%b pc=%h req=%b addr=%h want 0 01 1 01", bus.instr_valid, pc, bus.imem_req, bus.imem_addr);
        end
    endtask

    task automatic test_branch_taken();
        goto_pc(16);
        compared++;
        if (pc !== 8'h10 || bus.imem_addr !== 8'h10) begin
            mismatched++;
            $display("FAIL run_to_10: got pc=%h addr=%h want 10 10", pc, bus.imem_addr);
        end
        bus.imem_ack  = 1'b1;
        bus.imem_data = 8'hB0;
        cyc();
        bus.imem_data = 8'h05;
        compared++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 8'h11 || bus.instr_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL oper_addr: got req=%b addr=%h valid=%b want 1 11 0", bus.imem_req, bus.imem_addr, bus.instr_valid);
        end
        cyc();
        bus.imem_ack    = 1'b0;
        bus.branch_take = 1'b1;
        compared++;
        if (bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL branch_idle_bus: got req=%b valid=%b want 0 0", bus.imem_req, bus.instr_valid);
        end
        cyc();
        bus.branch_take = 1'b0;
        compared++;
        if (pc !== 8'h17 || flags !== 2'b00 || bus.imem_req !== 1'b1 || bus.imem_addr !== 8'h17) begin
            mismatched++;
            $display("FAIL br_taken_fwd: got pc=%h flags=%b req=%b addr=%h want 17 00 1 17", pc, flags, bus.imem_req, bus.imem_addr);
        end
    endtask

    task automatic test_branch_not_taken();
        goto_pc(16);
        bus.imem_ack  = 1'b1;
        bus.imem_data = 8'hB0;
        cyc();
        bus.imem_data = 8'h05;
        cyc();
        bus.imem_ack    = 1'b0;
        bus.branch_take = 1'b0;
        cyc();
        compared++;
        if (pc !== 8'h12 || flags !== 2'b00) begin
            mismatched++;
            $display("FAIL br_not_taken: got pc=%h flags=%b want 12 00", pc, flags);
        end
    endtask

    task automatic test_branch_backward();
        goto_pc(16);
        bus.imem_ack  = 1'b1;
        bus.imem_data = 8'hB0;
        cyc();
        bus.imem_data = 8'hF0;
        cyc();
        bus.imem_ack    = 1'b0;
        bus.branch_take = 1'b1;
        cyc();
        bus.branch_take = 1'b0;
        compared++;
        if (pc !== 8'h02 || flags !== 2'b11) begin
            mismatched++;
            $display("FAIL br_backward: got pc=%h flags=%b want 02 11", pc, flags);
        end
    endtask

    task automatic test_pc_wrap();
        goto_pc(255);
        compared++;
        if (pc !== 8'hFF || flags !== 2'b00) begin
            mismatched++;
            $display("FAIL run_to_ff: got pc=%h flags=%b want ff 00", pc, flags);
        end
        bus.imem_ack  = 1'b1;
        bus.imem_data = 8'h01;
        cyc();
        bus.imem_ack    = 1'b0;
        bus.instr_ready = 1'b1;
        cyc();
        bus.instr_ready = 1'b0;
        compared++;
        if (pc !== 8'h00 || flags !== 2'b10 || bus.imem_req !== 1'b1 || bus.imem_addr !== 8'h00) begin
            mismatched++;
            $display("FAIL pc_wrap: got pc=%h flags=%b req=%b addr=%h want 00 10 1 00", pc, flags, bus.imem_req, bus.imem_addr);
        end
    endtask

    task automatic test_halt();
        goto_pc(3);
        bus.imem_ack  = 1'b1;
        bus.imem_data = 8'hFF;
        cyc();
        compared++;
        if (halted !== 1'b1 || bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0 || pc !== 8'h03) begin
            mismatched++;
            $display("FAIL halt_enter: got halted=%b req=%b valid=%b pc=%h want 1 0 0 03", halted, bus.imem_req, bus.instr_valid, pc);
        end
        start           = 1'b1;
        bus.imem_data   = 8'h01;
        bus.instr_ready = 1'b1;
        repeat (5) cyc();
        start           = 1'b0;
        bus.imem_ack    = 1'b0;
        bus.instr_ready = 1'b0;
        compared++;
        if (halted !== 1'b1 || bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0 || pc !== 8'h03) begin
            mismatched++;
            $display("FAIL halt_sticky: got halted=%b req=%b valid=%b pc=%h want 1 0 0 03", halted, bus.imem_req, bus.instr_valid, pc);
        end
    endtask

    task automatic test_reset_in_oper();
        goto_pc(5);
        bus.imem_ack  = 1'b1;
        bus.imem_data = 8'hB2;
        cyc();
        bus.imem_ack = 1'b0;
        compared++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 8'h06) begin
            mismatched++;
            $display("FAIL oper_before_rst: got req=%b addr=%h want 1 06", bus.imem_req, bus.imem_addr);
        end
        #2;
        reset = 1'b1;
        #1;
        compared++;
        if (bus.imem_req !== 1'b0 || pc !== 8'h00 || bus.instr_out !== 8'h00) begin
            mismatched++;
            $display("FAIL async_rst: got req=%b pc=%h out=%h want 0 00 00", bus.imem_req, pc, bus.instr_out);
        end
        cyc();
        reset         = 1'b0;
        bus.imem_ack  = 1'b1;
        bus.imem_data = 8'h07;
        repeat (3) cyc();
        bus.imem_ack = 1'b0;
        compared++;
        if (bus.imem_req !== 1'b0 || pc !== 8'h00 || halted !== 1'b0) begin
            mismatched++;
            $display("FAIL rst_ack_ignored: got req=%b pc=%h halted=%b want 0 00 0", bus.imem_req, pc, halted);
        end
    endtask

    initial begin
        compared        = 0;
        mismatched      = 0;
        reset           = 1'b1;
        start           = 1'b0;
        bus.imem_ack    = 1'b0;
        bus.imem_data   = 8'h00;
        bus.instr_ready = 1'b0;
        bus.branch_take = 1'b0;
        #1;
        test_reset();
        test_issue_handshake();
        test_branch_taken();
        test_branch_not_taken();
        test_branch_backward();
        test_pc_wrap();
        test_halt();
        test_reset_in_oper();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
